// File: rtl/systolic_result_collector.sv
// Collects aligned partial-sum rows from the systolic core into a row FIFO and
// streams them out one element at a time; the core is never stalled.
module systolic_result_collector #(
    parameter int N         = 4,
    parameter int ACC_WIDTH = 32,
    parameter int DEPTH     = 8,
    parameter int ROW_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ROW_CNT_W-1:0]   num_rows,
    input  logic [N-1:0]           in_valid,
    input  logic [N*ACC_WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_WIDTH-1:0]   out_data,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic                   misalign
);

    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int CW    = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CW-1:0]    LAST_COL = CW'(N - 1);

    // Output stream: out_valid/out_data/out_last describe one element; it is
    // consumed on a cycle with out_valid && out_ready and held unchanged otherwise.
    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;
    state_t state;

    logic [ROW_CNT_W-1:0] rows_expected;
    logic [ROW_CNT_W-1:0] rows_received;
    logic [ROW_CNT_W-1:0] rows_next;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [CW-1:0]        col;
    logic [ACC_WIDTH-1:0] mem_data [DEPTH][N];
    logic                 mem_tag  [DEPTH];

    logic fifo_empty;
    logic fifo_full;
    logic row_event;
    logic partial_event;
    logic last_tag;
    logic handshake;
    logic pop;
    logic push;

    assign fifo_empty    = (count == '0);
    assign fifo_full     = (count == FULL_CNT);
    assign row_event     = (state == COLLECT) && (in_valid == {N{1'b1}});
    assign partial_event = (state == COLLECT) && (in_valid != '0) && (in_valid != {N{1'b1}});
    assign rows_next     = rows_received + ROW_CNT_W'(1);
    assign last_tag      = (rows_next == rows_expected);

    assign out_valid = (state != IDLE) && !fifo_empty;
    assign handshake = out_valid && out_ready;
    assign pop       = handshake && (col == LAST_COL);
    // A pop in the same cycle frees the slot, so a full FIFO can still take the row.
    assign push      = row_event && (!fifo_full || pop);
    assign out_data  = out_valid ? mem_data[rd_ptr][col] : '0;
    assign out_last  = out_valid && (col == LAST_COL) && mem_tag[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rows_expected <= '0;
            rows_received <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            overflow      <= 1'b0;
            misalign      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_rows != '0) begin
                            state         <= COLLECT;
                            busy          <= 1'b1;
                            rows_expected <= num_rows;
                            rows_received <= '0;
                            overflow      <= 1'b0;
                            misalign      <= 1'b0;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (row_event) begin
                        rows_received <= rows_next;
                        if (!push) overflow <= 1'b1;
                        if (last_tag) state <= DRAIN;
                    end else if (partial_event) begin
                        misalign <= 1'b1;
                    end
                end
                DRAIN: begin
                    // Finish on the edge that removes the last row, or at once if nothing is left.
                    if (fifo_empty || (pop && count == CNT_W'(1))) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            col    <= '0;
        end else begin
            if (handshake) col <= (col == LAST_COL) ? '0 : col + CW'(1);
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            for (int j = 0; j < N; j++) begin
                mem_data[wr_ptr][j] <= in_data[j*ACC_WIDTH +: ACC_WIDTH];
            end
            mem_tag[wr_ptr] <= last_tag;
        end
    end

endmodule

// File: tb/tb_systolic_result_collector.sv
// Bench for systolic_result_collector: directed tiles plus random tiles checked
// against a queue-based reference of the row FIFO and element stream.
module tb_systolic_result_collector;
    localparam int N     = 4;
    localparam int W     = 32;
    localparam int DEPTH = 8;
    localparam int RW    = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [RW-1:0] num_rows;
    logic [N-1:0]  in_valid;
    logic [N*W-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          overflow;
    logic          misalign;

    systolic_result_collector #(.N(N), .ACC_WIDTH(W), .DEPTH(DEPTH), .ROW_CNT_W(RW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows),
        .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .overflow(overflow), .misalign(misalign)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // {last, data} of every element still owed by the DUT, oldest first
    logic [W:0] exp_q[$];
    int cyc = 0, last_hs_cyc = 0, start_cyc = 0;
    int done_cnt = 0, exp_done_cnt = 0;
    int rows_exp = 0, rows_rx = 0;
    bit zero_tile = 1'b0, m_collect = 1'b0, exp_ovf = 1'b0, exp_mis = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [N*W-1:0] mk_row(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [W-1:0] c, input logic [W-1:0] e);
        return {e, c, b, a};
    endfunction

    function automatic logic [N*W-1:0] rand_row();
        logic [N*W-1:0] r;
        for (int j = 0; j < N; j++) r[j*W +: W] = $urandom;
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one cycle of inputs and updates the reference for the edge that samples them.
    task automatic drive_cycle(input logic [N-1:0] v, input logic [N*W-1:0] d,
                               input logic rdy, input logic st);
        int  sz;
        int  rows;
        bit  pop_now;
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        start     = st;
        if (st) num_rows = RW'(1);
        if (m_collect) begin
            if (v == {N{1'b1}}) begin
                sz      = exp_q.size();
                pop_now = rdy && (sz > 0) && (sz % N == 1);
                rows    = (sz + N - 1) / N;
                if (rows < DEPTH || pop_now) begin
                    for (int j = 0; j < N; j++)
                        exp_q.push_back({(j == N - 1) && (rows_rx + 1 == rows_exp), d[j*W +: W]});
                end else begin
                    exp_ovf = 1'b1;
                end
                rows_rx++;
                if (rows_rx == rows_exp) m_collect = 1'b0;
            end else if (v != '0) begin
                exp_mis = 1'b1;
            end
        end
        tick();
        start    = 1'b0;
        in_valid = '0;
    endtask

    task automatic start_tile(input int nr);
        start     = 1'b1;
        num_rows  = RW'(nr);
        in_valid  = '0;
        start_cyc = cyc;
        zero_tile = (nr == 0);
        if (nr > 0) begin
            m_collect = 1'b1;
            rows_exp  = nr;
            rows_rx   = 0;
            exp_ovf   = 1'b0;
            exp_mis   = 1'b0;
        end
        tick();
        start = 1'b0;
        check("busy_after_start", busy, nr > 0);
    endtask

    // rdy_mode 1: out_ready held high; otherwise random out_ready.
    task automatic wait_done(input int budget, input int rdy_mode);
        int base;
        int n;
        base = done_cnt;
        n    = 0;
        exp_done_cnt++;
        while (done_cnt == base && n < budget) begin
            drive_cycle('0, '0, (rdy_mode == 1) ? 1'b1 : ($urandom_range(0, 2) != 0), 1'b0);
            n++;
        end
        check("done_seen", done_cnt != base, 1);
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            if (done) begin
                done_cnt++;
                check("done_busy", busy, 0);
                if (zero_tile) begin
                    check("zero_done_latency", cyc, start_cyc + 2);
                end else begin
                    check("done_latency", cyc, last_hs_cyc + 1);
                    check("drained", exp_q.size(), 0);
                    check("overflow_flag", overflow, exp_ovf);
                    check("misalign_flag", misalign, exp_mis);
                end
            end
            if (exp_q.size() == 0) begin
                check("valid_when_empty", out_valid, 0);
            end else if (out_valid) begin
                check("element", {out_last, out_data}, exp_q[0]);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    last_hs_cyc = cyc;
                end
            end
        end
    end

    initial begin
        #500000;
        n_err++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int nr;
        int sel;
        logic [N-1:0] v;
        rst_n = 1'b0; start = 1'b0; num_rows = '0; in_valid = '0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_flags", {overflow, misalign}, 0);
        rst_n = 1'b1;
        tick();

        // basic two-row tile
        start_tile(2);
        drive_cycle('1, mk_row(1, 2, 3, 4), 1'b1, 1'b0);
        check("first_row_valid", out_valid, 1);
        check("first_row_lane0", out_data, 1);
        drive_cycle('1, mk_row(5, 6, 7, 8), 1'b1, 1'b0);
        wait_done(40, 1);

        // backpressure: head element must hold while out_ready is low
        start_tile(1);
        drive_cycle('1, mk_row(10, 20, 30, 40), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive_cycle('0, '0, 1'b0, 1'b0);
            check("bp_valid", out_valid, 1);
            check("bp_data", out_data, 10);
        end
        wait_done(40, 1);

        // start while busy is ignored
        start_tile(2);
        drive_cycle('1, mk_row(11, 12, 13, 14), 1'b1, 1'b1);
        check("busy_start_ignored", busy, 1);
        drive_cycle('1, mk_row(15, 16, 17, 18), 1'b1, 1'b1);
        wait_done(40, 1);

        // overflow: ten rows into an eight-row FIFO with no draining
        start_tile(10);
        for (int r = 0; r < 10; r++)
            drive_cycle('1, mk_row(W'(r*4+1), W'(r*4+2), W'(r*4+3), W'(r*4+4)), 1'b0, 1'b0);
        check("ovf_flag_now", overflow, 1);
        check("ovf_busy_drain", busy, 1);
        wait_done(100, 1);

        // full FIFO takes a new row on the cycle its head row is popped
        start_tile(9);
        for (int r = 0; r < 8; r++) drive_cycle('1, rand_row(), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive_cycle('0, '0, 1'b1, 1'b0);
        drive_cycle('1, mk_row(91, 92, 93, 94), 1'b1, 1'b0);
        check("full_pop_no_ovf", overflow, 0);
        wait_done(100, 1);

        // misaligned lanes are dropped and flagged
        start_tile(1);
        drive_cycle(4'b0011, mk_row(9, 9, 9, 9), 1'b1, 1'b0);
        check("misalign_now", misalign, 1);
        drive_cycle('1, mk_row(7, 7, 7, 7), 1'b1, 1'b0);
        wait_done(40, 1);

        // zero-row tile
        start_tile(0);
        wait_done(5, 1);

        // reset in the middle of a drain
        start_tile(3);
        for (int r = 0; r < 3; r++) drive_cycle('1, rand_row(), 1'b0, 1'b0);
        check("pre_reset_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_data", out_data, 0);
        exp_q.delete();
        m_collect = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("post_reset_valid", out_valid, 0);

        // random tiles
        for (int t = 0; t < 8; t++) begin
            nr = $urandom_range(1, 12);
            start_tile(nr);
            for (int c = 0; c < 300 && m_collect; c++) begin
                sel = $urandom_range(0, 9);
                if (sel < 6)      v = '1;
                else if (sel < 8) v = '0;
                else              v = N'($urandom_range(1, 14));
                drive_cycle(v, rand_row(), $urandom_range(0, 2) != 0, (c == 1));
            end
            wait_done(400, 0);
        end

        repeat (3) tick();
        check("done_count", done_cnt, exp_done_cnt);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
